// File: rtl/dht11_pkg.sv
// DHT11 bus timing, frame layout and FSM encodings.
// Shared by the sensor emulator and the DHT11 reader.
package dht11_pkg;

  localparam int CNT_W = 20;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t START_DET_CYC = 20'd800000;
  localparam cnt_t REL_WAIT_CYC  = 20'd2500;
  localparam cnt_t RESP_LOW_CYC  = 20'd4000;
  localparam cnt_t RESP_HIGH_CYC = 20'd4000;
  localparam cnt_t BIT_LOW_CYC   = 20'd2500;
  localparam cnt_t ZERO_HIGH_CYC = 20'd1300;
  localparam cnt_t ONE_HIGH_CYC  = 20'd3500;

  localparam int FRAME_W    = 40;
  localparam int RH_INT_LSB = 32;
  localparam int RH_DEC_LSB = 24;
  localparam int T_INT_LSB  = 16;
  localparam int T_DEC_LSB  = 8;
  localparam int CSUM_LSB   = 0;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_HOST_LOW  = 3'd1;
  localparam state_t S_WAIT_REL  = 3'd2;
  localparam state_t S_RESP_LOW  = 3'd3;
  localparam state_t S_RESP_HIGH = 3'd4;
  localparam state_t S_BIT_LOW   = 3'd5;
  localparam state_t S_BIT_HIGH  = 3'd6;
  localparam state_t S_END_LOW   = 3'd7;

  typedef struct packed {
    logic [7:0] rh_int;
    logic [7:0] rh_dec;
    logic [7:0] t_int;
    logic [7:0] t_dec;
  } payload_t;

  function automatic logic [7:0] calc_csum(
    input payload_t p,
    input logic     bad
  );
    logic [7:0] s;
    s = p.rh_int + p.rh_dec;
    s = s + p.t_int;
    s = s + p.t_dec;
    s = s + {7'd0, bad};
    return s;
  endfunction

endpackage

// File: rtl/dht11_sensor_emu_if.sv
// Payload and status bundle between a DHT11 emulator
// and whatever supplies its readings.
interface dht11_sensor_emu_if;

  logic [7:0] RH_integral;
  logic [7:0] RH_decimal;
  logic [7:0] T_integral;
  logic [7:0] T_decimal;
  logic       bad_csum;
  logic       busy;
  logic       frame_done;
  logic [7:0] Checksum;

  modport master (
    output RH_integral,
    output RH_decimal,
    output T_integral,
    output T_decimal,
    output bad_csum,
    input  busy,
    input  frame_done,
    input  Checksum
  );

  modport slave (
    input  RH_integral,
    input  RH_decimal,
    input  T_integral,
    input  T_decimal,
    input  bad_csum,
    output busy,
    output frame_done,
    output Checksum
  );

endinterface

// File: rtl/dht_sync2.sv
// Two-flop synchroniser for the DHT data line.
// Resets high to match an idle, pulled-up bus.
module dht_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dht11_sensor_emu.sv
// DHT11 responder: detects a host start pulse, answers
// with presence, then pulse-width encodes a 40-bit frame.
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter cnt_t START_DET = START_DET_CYC,
  parameter cnt_t REL_WAIT  = REL_WAIT_CYC,
  parameter cnt_t RESP_LOW  = RESP_LOW_CYC,
  parameter cnt_t RESP_HIGH = RESP_HIGH_CYC,
  parameter cnt_t BIT_LOW   = BIT_LOW_CYC,
  parameter cnt_t ZERO_HIGH = ZERO_HIGH_CYC,
  parameter cnt_t ONE_HIGH  = ONE_HIGH_CYC
) (
  input  logic clk_50M,
  input  logic reset,
  inout  wire  sensor,
  dht11_sensor_emu_if.slave bus
);

  logic s_in;

  dht_sync2 u_sync (
    .clk   (clk_50M),
    .reset (reset),
    .d     (sensor),
    .q     (s_in)
  );

  state_t             state;
  cnt_t               cnt;
  logic [5:0]         idx;
  logic [FRAME_W-1:0] frame;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         csum_q;

  payload_t   pl;
  logic [7:0] csum_nx;

  assign pl = '{
    rh_int: bus.RH_integral,
    rh_dec: bus.RH_decimal,
    t_int:  bus.T_integral,
    t_dec:  bus.T_decimal
  };

  assign csum_nx = calc_csum(pl, bus.bad_csum);

  cnt_t lim;
  logic ph_end;

  always_comb begin
    lim = REL_WAIT;
    unique case (state)
      S_RESP_LOW:  lim = RESP_LOW;
      S_RESP_HIGH: lim = RESP_HIGH;
      S_BIT_LOW:   lim = BIT_LOW;
      S_END_LOW:   lim = BIT_LOW;
      S_BIT_HIGH:  lim = frame[idx] ? ONE_HIGH
                                    : ZERO_HIGH;
      default:     lim = REL_WAIT;
    endcase
  end

  assign ph_end = (cnt == lim);

  always_ff @(posedge clk_50M) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      frame  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      csum_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!s_in) begin
            cnt   <= cnt_t'(1);
            state <= S_HOST_LOW;
          end
        end
        S_HOST_LOW: begin
          if (!s_in) begin
            if (cnt < START_DET)
              cnt <= cnt + cnt_t'(1);
          end else if (cnt >= START_DET) begin
            frame[RH_INT_LSB +: 8] <= pl.rh_int;
            frame[RH_DEC_LSB +: 8] <= pl.rh_dec;
            frame[T_INT_LSB +: 8]  <= pl.t_int;
            frame[T_DEC_LSB +: 8]  <= pl.t_dec;
            frame[CSUM_LSB +: 8]   <= csum_nx;
            csum_q <= csum_nx;
            busy_q <= 1'b1;
            cnt    <= cnt_t'(1);
            state  <= S_WAIT_REL;
          end else begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        S_WAIT_REL: begin
          // host pulled low again: treat as a fresh start attempt
          if (!s_in) begin
            busy_q <= 1'b0;
            cnt    <= cnt_t'(1);
            state  <= S_HOST_LOW;
          end else if (ph_end) begin
            cnt   <= cnt_t'(1);
            state <= S_RESP_LOW;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_RESP_LOW: begin
          if (ph_end) begin
            cnt   <= cnt_t'(1);
            state <= S_RESP_HIGH;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_RESP_HIGH: begin
          if (ph_end) begin
            cnt   <= cnt_t'(1);
            idx   <= 6'(FRAME_W - 1);
            state <= S_BIT_LOW;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_BIT_LOW: begin
          if (ph_end) begin
            cnt   <= cnt_t'(1);
            state <= S_BIT_HIGH;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_BIT_HIGH: begin
          if (ph_end) begin
            cnt <= cnt_t'(1);
            if (idx == 6'd0) begin
              state <= S_END_LOW;
            end else begin
              idx   <= idx - 6'd1;
              state <= S_BIT_LOW;
            end
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        S_END_LOW: begin
          if (ph_end) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  logic oe;
  logic dout;

  always_comb begin
    oe   = 1'b0;
    dout = 1'b0;
    unique case (state)
      S_RESP_LOW,
      S_BIT_LOW,
      S_END_LOW: oe = 1'b1;
      S_RESP_HIGH,
      S_BIT_HIGH: begin
        oe   = 1'b1;
        dout = 1'b1;
      end
      default: oe = 1'b0;
    endcase
  end

  assign sensor = oe ? dout : 1'bz;

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.Checksum   = csum_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// Scoreboard bench: host stimulus queues expected frames,
// a line monitor decodes pulse widths and compares.
module tb_dht11_sensor_emu;
  import dht11_pkg::*;

  localparam cnt_t SD = 20'd200;
  localparam cnt_t RW = 20'd20;
  localparam cnt_t RL = 20'd40;
  localparam cnt_t RH = 20'd40;
  localparam cnt_t BL = 20'd25;
  localparam cnt_t ZH = 20'd13;
  localparam cnt_t OH = 20'd35;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset    = 1'b0;
  logic host_low = 1'b0;
  wire  sensor;

  pullup (sensor);
  assign sensor = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emu_if bus ();

  dht11_sensor_emu #(
    .START_DET (SD),
    .REL_WAIT  (RW),
    .RESP_LOW  (RL),
    .RESP_HIGH (RH),
    .BIT_LOW   (BL),
    .ZERO_HIGH (ZH),
    .ONE_HIGH  (OH)
  ) dut (
    .clk_50M (clk),
    .reset   (reset),
    .sensor  (sensor),
    .bus     (bus)
  );

  typedef struct {
    logic [39:0] frame;
    logic        ok;
  } exp_t;

  exp_t sbq[$];
  int   checks    = 0;
  int   failures  = 0;
  int   mon_bits  = 0;
  int   done_cnt  = 0;
  logic abort     = 1'b0;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (sensor === lvl && !abort && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  always @(negedge clk)
    if (bus.frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin : monitor
    int          n;
    int          bad_lo;
    int          bad_hi;
    logic [39:0] got;
    logic [7:0]  s;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1 && !abort) begin
        mon_bits = 0;
        bad_lo   = 0;
        bad_hi   = 0;
        got      = '0;
        run_len(1'b1, n);
        if (!abort) chk("rel_wait", n, RW);
        run_len(1'b0, n);
        if (!abort) chk("resp_low", n, RL);
        run_len(1'b1, n);
        if (!abort) chk("resp_high", n, RH);
        for (int i = 0; i < 40 && !abort; i++) begin
          run_len(1'b0, n);
          if (n != BL) bad_lo++;
          run_len(1'b1, n);
          if (n == OH)      got = {got[38:0], 1'b1};
          else if (n == ZH) got = {got[38:0], 1'b0};
          else begin
            bad_hi++;
            got = {got[38:0], 1'bx};
          end
          mon_bits = i + 1;
        end
        run_len(1'b0, n);
        if (abort) begin
          if (sbq.size() > 0) void'(sbq.pop_front());
          wait (!abort);
        end else begin
          chk("end_low", n, BL);
          chk("bit_low_bad", bad_lo, 0);
          chk("bit_high_bad", bad_hi, 0);
          chk("frame_done_at_release", bus.frame_done, 1);
          if (sbq.size() == 0) begin
            chk("sb_underflow", sbq.size(), 1);
          end else begin
            e = sbq.pop_front();
            s = got[39:32] + got[31:24];
            s = s + got[23:16] + got[15:8];
            chk("frame", got, e.frame);
            chk("csum_valid", s === got[7:0], e.ok);
            chk("Checksum_port", bus.Checksum, e.frame[7:0]);
          end
          @(negedge clk);
          chk("busy_after", bus.busy, 0);
          chk("frame_done_pulse", bus.frame_done, 0);
        end
      end
    end
  end

  task automatic set_pl(
    input logic [7:0] a, input logic [7:0] b,
    input logic [7:0] c, input logic [7:0] d,
    input logic       bad
  );
    bus.RH_integral = a;
    bus.RH_decimal  = b;
    bus.T_integral  = c;
    bus.T_decimal   = d;
    bus.bad_csum    = bad;
  endtask

  task automatic push(input logic [39:0] f, input logic ok);
    exp_t e;
    e.frame = f;
    e.ok    = ok;
    sbq.push_back(e);
  endtask

  task automatic host_start(input int low, input logic real_start);
    @(negedge clk);
    host_low = 1'b1;
    repeat (low) @(negedge clk);
    host_low = 1'b0;
    if (real_start) begin
      repeat (2) @(negedge clk);
      chk("busy_lat_2", bus.busy, 0);
      @(negedge clk);
      chk("busy_lat_3", bus.busy, 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_timeout", n < 4000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int busy_seen;
    int low_seen;
    set_pl(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_Checksum", bus.Checksum, 0);
    chk("rst_line", sensor, 1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    set_pl(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
    push(40'h37_00_19_05_55, 1'b1);
    host_start(250, 1'b1);
    wait_done();
    chk("done_once", done_cnt, 1);

    set_pl(8'h37, 8'h00, 8'h19, 8'h05, 1'b1);
    push(40'h37_00_19_05_56, 1'b0);
    host_start(250, 1'b1);
    wait_done();

    host_start(50, 1'b0);
    busy_seen = 0;
    low_seen  = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) busy_seen++;
      if (sensor !== 1'b1)   low_seen++;
    end
    chk("short_busy", busy_seen, 0);
    chk("short_line", low_seen, 0);

    set_pl(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    push(40'hFF_FF_FF_FF_FC, 1'b1);
    host_start(250, 1'b1);
    wait_done();

    set_pl(8'hA5, 8'h5A, 8'h12, 8'h34, 1'b0);
    push(40'hA5_5A_12_34_45, 1'b1);
    host_start(250, 1'b1);
    n = 0;
    while (!(mon_bits == 20 && sensor === 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_bit20", n < 3000, 1);
    abort = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_line", sensor, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_Checksum", bus.Checksum, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    abort = 1'b0;
    repeat (5) @(negedge clk);
    push(40'hA5_5A_12_34_45, 1'b1);
    host_start(250, 1'b1);
    wait_done();

    set_pl(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
    push(40'h11_22_33_44_AA, 1'b1);
    host_start(250, 1'b1);
    repeat (int'(RW + RL) + 10) @(negedge clk);
    set_pl(8'hEE, 8'h01, 8'h02, 8'h03, 1'b1);
    wait_done();

    chk("done_total", done_cnt, 5);
    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/dht11_sensor_emu.md
# dht11_sensor_emu

Single-wire DHT11 sensor emulator: the responder end of the DHT11 bus protocol. It detects a host start pulse on the shared data line, answers with the 80 µs low / 80 µs high presence response, then serialises a 40-bit frame (RH int, RH dec, T int, T dec, checksum) using DHT11 pulse-width encoding. It is the bench and hardware-loopback partner for the team's DHT11 reader, and can stand in for a physical sensor on the board.

## Interface
- START_DET_CYC, 800000: minimum host low time accepted as a start (16 ms)
- REL_WAIT_CYC, 2500: wait after line returns high before responding (50 µs)
- RESP_LOW_CYC, 4000: response low (80 µs)
- RESP_HIGH_CYC, 4000: response high (80 µs)
- BIT_LOW_CYC, 2500: per-bit low preamble, also end-of-frame low (50 µs)
- ZERO_HIGH_CYC, 1300: high time for '0' (26 µs)
- ONE_HIGH_CYC, 3500: high time for '1' (70 µs)

Ports:
- clk_50M  in  1  50 MHz clock
- reset  in  1  synchronous, active-low
- sensor  inout  1  DHT data line; driven push-pull only while responding, otherwise 'z' (board/bench pull-up)
- RH_integral, RH_decimal, T_integral, T_decimal  in  8 each  payload bytes
- bad_csum  in  1  when high at snapshot, transmitted checksum = correct sum + 1
- busy  out  1  high from start detection to end of frame
- frame_done  out  1  one-cycle pulse after end-of-frame release
- Checksum  out  8  checksum of last snapshot

## Operation
- Input path: sensor passes a 2-flop synchroniser; all decisions use the synchronised value `s_in`.
- States:
  - IDLE: line released; `s_in`=0 → cnt=1, HOST_LOW.
  - HOST_LOW: `s_in`=0 → cnt++ (saturates at START_DET_CYC). `s_in`=1: if cnt ≥ START_DET_CYC → snapshot payload, compute Checksum, busy=1, cnt=1, WAIT_REL; else → IDLE (short glitch ignored).
  - WAIT_REL: line released; count REL_WAIT_CYC cycles, then drive 0, RESP_LOW. If `s_in`=0 during the wait, restart in HOST_LOW (host retried).
  - RESP_LOW: drive 0 RESP_LOW_CYC cycles, then RESP_HIGH.
  - RESP_HIGH: drive 1 RESP_HIGH_CYC cycles, then BIT_LOW with bit index 39.
  - BIT_LOW: drive 0 BIT_LOW_CYC cycles, then BIT_HIGH.
  - BIT_HIGH: drive 1 for ONE_HIGH_CYC if frame[idx]=1 else ZERO_HIGH_CYC; idx=0 → END_LOW, else idx--, BIT_LOW.
  - END_LOW: drive 0 BIT_LOW_CYC cycles, release line, busy=0, frame_done=1, → IDLE.
- Frame: {RH_integral, RH_decimal, T_integral, T_decimal, Checksum}, MSB first, bit 39 sent first.
- Checksum = (RH_integral+RH_decimal+T_integral+T_decimal) mod 256, plus 1 (mod 256) if bad_csum.
- Payload inputs changing while busy have no effect on the frame in flight.
- In transmit states the line is not monitored; host contention is the host's fault.

## Timing
- Reset (next edge with reset=0): state IDLE, line 'z', busy=0, frame_done=0, Checksum=0, synchroniser=1, counters=0. Reset mid-frame releases the line at that edge.
- Start detection latency: busy rises 3 cycles after the raw line rises (2 sync + 1 register).
- Each drive phase lasts exactly its parameter count in clk_50M cycles, ±0; phase boundaries are back-to-back, no idle cycle.
- Total frame after response: 40×BIT_LOW_CYC + Σ high times + BIT_LOW_CYC.
- frame_done asserts on the cycle the line returns to 'z'.
- Counters: 20 bits (covers START_DET_CYC).

## Structure
- Shared package dht11_pkg: all timing constants above (shared with reader), state enum, frame layout offsets.
- One sub-module: dht_sync2 (2-flop synchroniser, reset value 1).

## Test plan
- RH=0x37, RHd=0x00, T=0x19, Td=0x05 → frame 0x37_00_19_05_55; Checksum=0x55; frame_done once; DHT reader loopback gives data_valid with the same bytes.
- bad_csum=1 with the same payload → transmitted checksum 0x56; reader produces no data_valid.
- Host low 100 µs (5000 cycles) then high → stays IDLE, busy=0, line never driven.
- All bytes 0xFF → checksum 0xFC (wrap); high widths measured at exactly 3500 for ones and 1300 for zeros.
- Reset asserted during bit 20 → line 'z' next cycle, busy=0; subsequent 18 ms start yields a full correct frame.
- Payload changed during RESP_HIGH → transmitted frame matches the snapshot values.
